sram1rw_arbiter: RTL and testbench

- Shares one single-port 256x46 SRAM macro between two requesters (port 0, port 1). Each requester has a valid/ready request channel and a valid/ready read-response channel.
- Round-robin arbitration picks one access per cycle and drives the macro pins directly. The macro clock CE is tied to clk at the parent level.
- Each port has a 2-entry response FIFO with credit-based read admission, so a stalled consumer never blocks the other port or loses data.

---
 rtl/sram1rw_arbiter.sv | 147 ++++++++++++++
 tb/tb_sram1rw_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram1rw_arbiter.sv
// Two-port round-robin front end for a single-port 256x46 SRAM macro.
// Per-port 2-entry read-response FIFOs with credit-gated read admission.
module sram1rw_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 46
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_we,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_rsp_valid,
  input  logic              p0_rsp_ready,
  output logic [DATA_W-1:0] p0_rsp_rdata,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_we,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p1_rsp_valid,
  input  logic              p1_rsp_ready,
  output logic [DATA_W-1:0] p1_rsp_rdata,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o
);

  logic              ptr;
  logic [1:0]        pend;
  logic [1:0]        hd;
  logic [1:0]        fc   [2];
  logic [DATA_W-1:0] mem  [2][2];

  logic [1:0]        vld;
  logic [1:0]        we;
  logic [1:0]        rdy;
  logic [1:0]        rv;
  logic [1:0]        pop;
  logic [1:0]        elig;
  logic [1:0]        req;
  logic [1:0]        grant;
  logic [1:0]        cnt  [2];
  logic [ADDR_W-1:0] addr [2];
  logic [DATA_W-1:0] wd   [2];
  logic              sel;
  logic              any;

  assign vld     = {p1_req_valid, p0_req_valid};
  assign we      = {p1_req_we, p0_req_we};
  assign rdy     = {p1_rsp_ready, p0_rsp_ready};
  assign addr[0] = p0_req_addr;
  assign addr[1] = p1_req_addr;
  assign wd[0]   = p0_req_wdata;
  assign wd[1]   = p1_req_wdata;

  // credits = in-flight read + stored entries; a same-cycle pop frees one
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      rv[n]   = fc[n] != 2'd0;
      pop[n]  = rv[n] & rdy[n];
      cnt[n]  = fc[n] + {1'b0, pend[n]};
      elig[n] = we[n] | (cnt[n] < 2'd2) | pop[n];
      req[n]  = vld[n] & elig[n];
    end
  end

  // round-robin grant, pointer port wins ties
  always_comb begin
    grant = 2'b00;
    if (req[ptr])
      grant[ptr] = 1'b1;
    else if (req[~ptr])
      grant[~ptr] = 1'b1;
  end

  assign sel = grant[1];
  assign any = |grant;

  assign p0_req_ready = grant[0];
  assign p1_req_ready = grant[1];

  // macro pins follow the granted port; idle pins are parked
  always_comb begin
    sram_csb = 1'b1;
    sram_web = 1'b1;
    sram_a   = '0;
    sram_i   = '0;
    if (any) begin
      sram_csb = 1'b0;
      sram_web = ~we[sel];
      sram_a   = addr[sel];
      sram_i   = wd[sel];
    end
  end

  assign sram_oeb = 1'b0;

  assign p0_rsp_valid = rv[0];
  assign p1_rsp_valid = rv[1];
  assign p0_rsp_rdata = rv[0] ? mem[0][hd[0]] : '0;
  assign p1_rsp_rdata = rv[1] ? mem[1][hd[1]] : '0;

  // pointer hands priority to the port that lost (or did not ask)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= 1'b0;
    else if (any)
      ptr <= ~sel;
  end

  // read-pending flags and FIFO occupancy/head pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 2'b00;
      hd   <= 2'b00;
      fc[0] <= 2'd0;
      fc[1] <= 2'd0;
    end else begin
      pend <= grant & ~we;
      for (int n = 0; n < 2; n++) begin
        if (pop[n])
          hd[n] <= ~hd[n];
        fc[n] <= fc[n] + {1'b0, pend[n]} - {1'b0, pop[n]};
      end
    end
  end

  // FIFO storage: macro data lands the cycle after its read grant
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++)
      if (pend[n])
        mem[n][hd[n] ^ fc[n][0]] <= sram_o;
  end

  // a push into a full FIFO without a pop means the credits were wrong
  always_ff @(posedge clk) begin
    for (int n = 0; n < 2; n++)
      if (rst_n)
        assert (!(pend[n] && !pop[n] && fc[n] == 2'd2));
  end

endmodule

// File: tb/tb_sram1rw_arbiter.sv
// Randomized bench for sram1rw_arbiter against a queue-based model.
// Includes a behavioural model of the single-port macro.
module tb_sram1rw_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req_valid, p0_req_ready, p0_req_we;
  logic [7:0]  p0_req_addr;
  logic [45:0] p0_req_wdata;
  logic        p0_rsp_valid, p0_rsp_ready;
  logic [45:0] p0_rsp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_we;
  logic [7:0]  p1_req_addr;
  logic [45:0] p1_req_wdata;
  logic        p1_rsp_valid, p1_rsp_ready;
  logic [45:0] p1_rsp_rdata;
  logic        sram_csb, sram_web, sram_oeb;
  logic [7:0]  sram_a;
  logic [45:0] sram_i;
  logic [45:0] sram_o = '0;

  sram1rw_arbiter #(.ADDR_W(8), .DATA_W(46)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_req_we(p0_req_we), .p0_req_addr(p0_req_addr),
    .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready),
    .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_req_we(p1_req_we), .p1_req_addr(p1_req_addr),
    .p1_req_wdata(p1_req_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready),
    .p1_rsp_rdata(p1_rsp_rdata),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb),
    .sram_a(sram_a), .sram_i(sram_i), .sram_o(sram_o)
  );

  always #5 clk = ~clk;

  // macro model: registers read data at the edge of the access
  logic [45:0] smem [256];
  always @(posedge clk)
    if (!sram_csb) begin
      if (!sram_web) smem[sram_a] <= sram_i;
      else           sram_o <= smem[sram_a];
    end

  typedef struct {
    logic [45:0] d;
    int          t;
  } ent_t;

  ent_t        q0[$];
  ent_t        q1[$];
  logic [45:0] rmem [256];
  int          ptr_m;
  int          cyc;
  int          checks;
  int          errors;

  logic        nv  [2];
  logic        nwe [2];
  logic [7:0]  na  [2];
  logic [45:0] nd  [2];
  logic        nrr [2];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic idle();
    for (int n = 0; n < 2; n++) begin
      nv[n] = 1'b0; nwe[n] = 1'b0; na[n] = '0; nd[n] = '0;
      nrr[n] = 1'b1;
    end
  endtask

  task automatic step();
    int          g;
    int          sz  [2];
    logic        ev  [2];
    logic        el  [2];
    logic [45:0] hdd [2];
    logic [7:0]  ea;
    logic [45:0] ei;
    logic        ew;
    @(negedge clk);
    p0_req_valid = nv[0]; p0_req_we = nwe[0];
    p0_req_addr = na[0]; p0_req_wdata = nd[0]; p0_rsp_ready = nrr[0];
    p1_req_valid = nv[1]; p1_req_we = nwe[1];
    p1_req_addr = na[1]; p1_req_wdata = nd[1]; p1_rsp_ready = nrr[1];
    #1;
    sz[0] = q0.size();
    sz[1] = q1.size();
    ev[0] = sz[0] > 0 && q0[0].t <= cyc;
    ev[1] = sz[1] > 0 && q1[0].t <= cyc;
    hdd[0] = ev[0] ? q0[0].d : '0;
    hdd[1] = ev[1] ? q1[0].d : '0;
    for (int n = 0; n < 2; n++)
      el[n] = nwe[n] || sz[n] < 2 || (ev[n] && nrr[n]);
    g = -1;
    if (nv[ptr_m] && el[ptr_m]) g = ptr_m;
    else if (nv[1-ptr_m] && el[1-ptr_m]) g = 1 - ptr_m;
    ea = '0; ei = '0; ew = 1'b1;
    if (g >= 0) begin
      ea = na[g]; ei = nd[g]; ew = ~nwe[g];
    end
    chk("p0_req_ready", 64'(p0_req_ready), 64'(g == 0));
    chk("p1_req_ready", 64'(p1_req_ready), 64'(g == 1));
    chk("sram_csb", 64'(sram_csb), 64'(g < 0));
    chk("sram_web", 64'(sram_web), 64'(ew));
    chk("sram_oeb", 64'(sram_oeb), 64'(0));
    chk("sram_a", 64'(sram_a), 64'(ea));
    chk("sram_i", 64'(sram_i), 64'(ei));
    chk("p0_rsp_valid", 64'(p0_rsp_valid), 64'(ev[0]));
    chk("p1_rsp_valid", 64'(p1_rsp_valid), 64'(ev[1]));
    chk("p0_rsp_rdata", 64'(p0_rsp_rdata), 64'(hdd[0]));
    chk("p1_rsp_rdata", 64'(p1_rsp_rdata), 64'(hdd[1]));
    @(posedge clk);
    if (ev[0] && nrr[0]) void'(q0.pop_front());
    if (ev[1] && nrr[1]) void'(q1.pop_front());
    if (g >= 0) begin
      if (nwe[g]) rmem[na[g]] = nd[g];
      else if (g == 0) q0.push_back('{rmem[na[0]], cyc + 2});
      else q1.push_back('{rmem[na[1]], cyc + 2});
      ptr_m = 1 - g;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle();
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    p0_req_we = 1'b0; p1_req_we = 1'b0;
    q0.delete();
    q1.delete();
    ptr_m = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; ptr_m = 0;
    for (int i = 0; i < 256; i++) begin
      smem[i] = '0;
      rmem[i] = '0;
    end
    idle();
    p0_req_valid = 1'b0; p0_req_we = 1'b0; p0_req_addr = '0;
    p0_req_wdata = '0; p0_rsp_ready = 1'b1;
    p1_req_valid = 1'b0; p1_req_we = 1'b0; p1_req_addr = '0;
    p1_req_wdata = '0; p1_rsp_ready = 1'b1;
    do_reset();
    step();

    // write then read back 0x05
    nv[0] = 1; nwe[0] = 1; na[0] = 8'h05; nd[0] = 46'h2A5A5A5A5A5;
    step();
    idle(); step(); step();
    nv[0] = 1; na[0] = 8'h05;
    step();
    idle(); repeat (3) step();

    // both ports contend, alternate
    for (int i = 0; i < 10; i++) begin
      nv[0] = 1; na[0] = 8'(i); nv[1] = 1; na[1] = 8'(i + 1);
      step();
    end
    idle(); repeat (3) step();

    // p1 backpressure with p0 traffic
    for (int i = 0; i < 4; i++) begin
      nv[0] = 1; na[0] = 8'(i); nv[1] = 1; na[1] = 8'(i + 2);
      nrr[1] = 0;
      step();
    end
    nv[0] = 0; nv[1] = 1; nrr[1] = 0;
    repeat (3) step();
    nrr[1] = 1;
    repeat (4) step();
    idle(); repeat (3) step();

    // p0 alone, back-to-back reads 0..7
    for (int i = 0; i < 8; i++) begin
      nv[0] = 1; na[0] = 8'(i);
      step();
    end
    idle(); repeat (3) step();

    // fill p0 credits, then pop and read in the same cycle
    nv[0] = 1; na[0] = 8'h05; nrr[0] = 0;
    step(); step();
    nv[0] = 0; step(); step();
    nv[0] = 1; na[0] = 8'h01; nrr[0] = 0; step();
    nrr[0] = 1; step(); step();
    idle(); repeat (4) step();

    // reset one cycle after a read grant
    nv[0] = 1; na[0] = 8'h05;
    step();
    do_reset();
    idle(); repeat (3) step();
    nv[0] = 1; nv[1] = 1; na[0] = 8'h02; na[1] = 8'h03;
    step();
    idle(); repeat (3) step();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      for (int n = 0; n < 2; n++) begin
        nv[n]  = $urandom_range(0, 3) != 0;
        nwe[n] = $urandom_range(0, 3) == 0;
        na[n]  = 8'($urandom_range(0, 15));
        nd[n]  = 46'({$urandom(), $urandom()});
        nrr[n] = $urandom_range(0, 3) != 0;
      end
      if ((i / 40) % 3 == 1) nrr[1] = 1'b0;
      if ((i / 60) % 4 == 2) nrr[0] = 1'b0;
      step();
      if (i == 1000) do_reset();
    end
    idle(); repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
